// File: rtl/logic_unit_pkg.sv
// Shared encodings for the sequential bitwise logic unit: opcode values and
// controller state encoding.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_slice_op.sv
// Combinational bitwise operator applied to one SLICE-bit operand slice.
module logic_slice_op
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Sequential multi-op logic unit: latches operands on start, evaluates one
// SLICE per cycle (LSB first), then publishes out/zero with a done pulse.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("logic_unit_seq: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [2:0]                    op_q;
  logic [NSLICE-1:0][SLICE-1:0]  a_q;
  logic [NSLICE-1:0][SLICE-1:0]  b_q;
  logic [NSLICE-1:0][SLICE-1:0]  work;
  logic [NSLICE-1:0][SLICE-1:0]  work_next;
  logic [SLICE-1:0]              a_sel;
  logic [SLICE-1:0]              b_sel;
  logic [SLICE-1:0]              res;
  logic                          last;

  // With a single slice the counter never indexes, so select slice 0 directly.
  if (NSLICE == 1) begin : g_one_slice
    assign a_sel = a_q[0];
    assign b_sel = b_q[0];
    always_comb begin
      work_next    = work;
      work_next[0] = res;
    end
  end else begin : g_multi_slice
    assign a_sel = a_q[cnt];
    assign b_sel = b_q[cnt];
    always_comb begin
      work_next      = work;
      work_next[cnt] = res;
    end
  end

  logic_slice_op #(.SLICE(SLICE)) u_slice_op (
    .op (op_q),
    .a  (a_sel),
    .b  (b_sel),
    .y  (res)
  );

  assign last = (cnt == LAST);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= OP_AND;
      a_q   <= '0;
      b_q   <= '0;
      work  <= '0;
      out   <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
        IDLE, DONE: begin
          if (start) begin
            a_q   <= i0;
            b_q   <= i1;
            op_q  <= op;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work <= work_next;
          cnt  <= cnt + CW'(1);
          if (last) begin
            out   <= work_next;
            zero  <= (work_next == '0);
            cnt   <= '0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: table of single operations plus
// hand-written sequences for ignore/latch, back-to-back, reset and SLICE=WIDTH.
module tb_logic_unit_seq;

  localparam logic [2:0] T_AND  = 3'b000;
  localparam logic [2:0] T_OR   = 3'b001;
  localparam logic [2:0] T_XOR  = 3'b010;
  localparam logic [2:0] T_NOR  = 3'b011;
  localparam logic [2:0] T_NAND = 3'b100;
  localparam logic [2:0] T_XNOR = 3'b101;
  localparam logic [2:0] T_ANDN = 3'b110;
  localparam logic [2:0] T_PASS = 3'b111;

  logic        clk;
  logic        reset;
  logic        start;
  logic        start32;
  logic [2:0]  op;
  logic [31:0] i0;
  logic [31:0] i1;
  logic [31:0] out;
  logic        zero;
  logic        busy;
  logic        done;
  logic [31:0] out32;
  logic        zero32;
  logic        busy32;
  logic        done32;

  int tests;
  int fails;
  logic [31:0] exp_q[$];
  logic [31:0] last_out;
  logic        last_zero;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[10];

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .i0    (i0),
    .i1    (i1),
    .out   (out),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  logic_unit_seq #(.WIDTH(32), .SLICE(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .start (start32),
    .op    (op),
    .i0    (i0),
    .i1    (i1),
    .out   (out32),
    .zero  (zero32),
    .busy  (busy32),
    .done  (done32)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  // Single operation: accept, scramble inputs, watch RUN, score against exp_q.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_o, input logic exp_z);
    int edges;
    int bad;
    logic [31:0] exp_v;
    op = o; i0 = a; i1 = b; start = 1'b1;
    tick();
    start = 1'b0;
    i0 = $urandom; i1 = $urandom; op = 3'($urandom_range(0, 7));
    exp_q.push_back(exp_o);
    edges = 0;
    bad = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy !== 1'b1 || out !== last_out || zero !== last_zero) bad++;
      tick();
      edges++;
    end
    check({name, " busy/hold"}, 32'(bad), 32'd0);
    check({name, " latency"}, 32'(edges), 32'd4);
    exp_v = exp_q.pop_front();
    check({name, " out"}, out, exp_v);
    check({name, " zero"}, 32'(zero), 32'(exp_z));
    check({name, " busy@done"}, 32'(busy), 32'd0);
    tick();
    check({name, " done pulse width"}, 32'(done), 32'd0);
    last_out = exp_o;
    last_zero = exp_z;
  endtask

  task automatic reset_mid_run(input string name);
    int pulses;
    op = T_PASS; i0 = 32'h1234_5678; i1 = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " done"}, 32'(done), 32'd0);
    check({name, " out"}, out, 32'h0);
    check({name, " zero"}, 32'(zero), 32'd0);
    pulses = 0;
    repeat (8) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check({name, " no done after abort"}, 32'(pulses), 32'd0);
    last_out = 32'h0;
    last_zero = 1'b0;
  endtask

  initial begin
    int edges;
    int extra;
    tests = 0;
    fails = 0;
    reset = 1'b1; start = 1'b0; start32 = 1'b0;
    op = T_AND; i0 = '0; i1 = '0;
    last_out = '0; last_zero = 1'b0;

    vecs[0] = '{"nor",      T_NOR,  32'h0000_FFFF, 32'h00FF_00FF, 32'hFF00_0000, 1'b0};
    vecs[1] = '{"xor_eq",   T_XOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1};
    vecs[2] = '{"andn",     T_ANDN, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0000_F0F0, 1'b0};
    vecs[3] = '{"and",      T_AND,  32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0};
    vecs[4] = '{"or",       T_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[5] = '{"nand",     T_NAND, 32'h1234_5678, 32'h0F0F_0F0F, 32'hFDFB_F9F7, 1'b0};
    vecs[6] = '{"xnor",     T_XNOR, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFF00_00FF, 1'b0};
    vecs[7] = '{"pass",     T_PASS, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[8] = '{"and_ends", T_AND,  32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 1'b0};
    vecs[9] = '{"or_zero",  T_OR,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

    repeat (3) tick();
    reset = 1'b0;
    check("reset out", out, 32'h0);
    check("reset zero", 32'(zero), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);

    for (int k = 0; k < 10; k++) begin
      run_op(vecs[k].name, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].exp_out, vecs[k].exp_zero);
    end

    // start during RUN is ignored; operands were latched on the accept edge
    op = T_AND; i0 = 32'h1234_5678; i1 = 32'h0F0F_0F0F; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = T_OR; i0 = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    wait_done(edges);
    check("ignore latency", 32'(edges + 2), 32'd4);
    check("ignore out", out, 32'h0204_0608);
    extra = 0;
    repeat (8) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    check("ignore single done", 32'(extra), 32'd0);

    reset_mid_run("reset_a");

    // back-to-back: start held through DONE
    op = T_XOR; i0 = 32'hA5A5_A5A5; i1 = 32'h5A5A_5A5A; start = 1'b1;
    tick();
    wait_done(edges);
    check("b2b first latency", 32'(edges), 32'd4);
    check("b2b first out", out, 32'hFFFF_FFFF);
    op = T_NAND; i0 = 32'hFFFF_FFFF; i1 = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    check("b2b re-accept busy", 32'(busy), 32'd1);
    check("b2b re-accept done", 32'(done), 32'd0);
    wait_done(edges);
    check("b2b second latency", 32'(edges), 32'd4);
    check("b2b second out", out, 32'h0);
    check("b2b second zero", 32'(zero), 32'd1);
    tick();

    reset_mid_run("reset_b");
    run_op("pass_after_reset", T_PASS, 32'hDEAD_BEEF, 32'h5555_AAAA, 32'hDEAD_BEEF, 1'b0);

    // reset wins over start on the same edge
    reset = 1'b1; start = 1'b1; op = T_PASS; i0 = 32'h0000_0001;
    tick();
    reset = 1'b0; start = 1'b0;
    check("reset priority busy", 32'(busy), 32'd0);
    tick();
    check("reset priority idle", 32'(busy), 32'd0);
    last_out = 32'h0;
    last_zero = 1'b0;

    // single-slice build: done one edge after accept
    op = T_XNOR; i0 = 32'h0000_FFFF; i1 = 32'h00FF_00FF; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    i0 = $urandom; i1 = $urandom;
    check("s32 busy", 32'(busy32), 32'd1);
    check("s32 done early", 32'(done32), 32'd0);
    tick();
    check("s32 done", 32'(done32), 32'd1);
    check("s32 out", out32, 32'hFF00_00FF);
    check("s32 zero", 32'(zero32), 32'd0);
    tick();
    check("s32 done width", 32'(done32), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
